// File: rtl/eoc_status_bank_if.sv
// Completion request handshake between the status bank and its controller.
// The bank drives the presented request; the controller returns the acknowledge.
interface eoc_status_bank_if #(
    parameter int CH_W = 2
);
    logic            req_valid;
    logic [CH_W-1:0] req_ch;
    logic            req_err;
    logic            ack;

    modport master (output req_valid, req_ch, req_err, input ack);
    modport slave  (input req_valid, req_ch, req_err, output ack);
endinterface

// File: rtl/eoc_status_bank.sv
// Multi-channel end-of-conversion tracker: per-channel IDLE/BUSY/DONE/ERR state with a
// watchdog, and a lowest-index-first arbiter presenting DONE/ERR channels for acknowledge.
module eoc_status_bank #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int TO_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] i_start,
    input  logic [NUM_CH-1:0] i_preset_eoc,
    input  logic [NUM_CH-1:0] i_clear_eoc,
    input  logic [TO_W-1:0]   i_timeout_limit,
    input  logic [NUM_CH-1:0] i_irq_en,
    output logic [NUM_CH-1:0] o_eoc_out,
    output logic [NUM_CH-1:0] o_busy,
    output logic [NUM_CH-1:0] o_timeout_err,
    output logic              o_irq,
    output logic              o_all_done,
    eoc_status_bank_if.master io_req
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } ch_state_t;

    ch_state_t       r_state    [NUM_CH];
    ch_state_t       w_state_nx [NUM_CH];
    logic [TO_W-1:0] r_cnt      [NUM_CH];
    logic [TO_W-1:0] w_cnt_nx   [NUM_CH];
    logic [TO_W-1:0] r_lim      [NUM_CH];
    logic [TO_W-1:0] w_lim_nx   [NUM_CH];

    logic              r_req_valid;
    logic [CH_W-1:0]   r_req_ch;
    logic              r_req_err;
    logic              r_irq;
    logic              w_req_valid_nx;
    logic [CH_W-1:0]   w_req_ch_nx;
    logic              w_req_err_nx;
    logic              w_ack_hit;
    logic [NUM_CH-1:0] w_pend;

    assign w_ack_hit = io_req.ack && r_req_valid;

    // Per-channel next state, priority clear > start > preset > ack > watchdog.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            // NOTE: every combinational output gets a default first so no path can infer a latch.
            w_state_nx[i] = r_state[i];
            w_cnt_nx[i]   = r_cnt[i];
            w_lim_nx[i]   = r_lim[i];
            if (i_clear_eoc[i]) begin
                w_state_nx[i] = ST_IDLE;
            end else if (i_start[i]) begin
                w_state_nx[i] = ST_BUSY;
                w_cnt_nx[i]   = '0;
                w_lim_nx[i]   = i_timeout_limit;
            end else if (i_preset_eoc[i] &&
                         (r_state[i] == ST_IDLE || r_state[i] == ST_BUSY)) begin
                w_state_nx[i] = ST_DONE;
            end else if (w_ack_hit && r_req_ch == CH_W'(i) &&
                         (r_state[i] == ST_DONE || r_state[i] == ST_ERR)) begin
                w_state_nx[i] = ST_IDLE;
            end else if (r_state[i] == ST_BUSY && r_lim[i] != '0) begin
                if (r_cnt[i] == r_lim[i] - TO_W'(1)) begin
                    w_state_nx[i] = ST_ERR;
                end else begin
                    w_cnt_nx[i] = r_cnt[i] + TO_W'(1);
                end
            end
        end
    end

    // A channel leaving DONE/ERR on this very edge is not worth presenting.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_pend[i] = (r_state[i] == ST_DONE || r_state[i] == ST_ERR) &&
                        !i_clear_eoc[i] && !i_start[i];
        end
    end

    always_comb begin
        w_req_valid_nx = r_req_valid;
        w_req_ch_nx    = r_req_ch;
        w_req_err_nx   = r_req_err;
        if (r_req_valid) begin
            if (io_req.ack || i_clear_eoc[r_req_ch] || i_start[r_req_ch]) begin
                w_req_valid_nx = 1'b0;
            end
        end else begin
            // Arbitrating only from the idle state enforces one low cycle after every drop.
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (w_pend[i]) begin
                    w_req_valid_nx = 1'b1;
                    w_req_ch_nx    = CH_W'(i);
                    w_req_err_nx   = (r_state[i] == ST_ERR);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: this small register bank is reset in full; it is not a RAM and must abort mid-run.
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
                r_lim[i]   <= '0;
            end
            r_req_valid <= 1'b0;
            r_req_ch    <= '0;
            r_req_err   <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= w_state_nx[i];
                r_cnt[i]   <= w_cnt_nx[i];
                r_lim[i]   <= w_lim_nx[i];
            end
            r_req_valid <= w_req_valid_nx;
            r_req_ch    <= w_req_ch_nx;
            r_req_err   <= w_req_err_nx;
            r_irq       <= |((o_eoc_out | o_timeout_err) & i_irq_en);
        end
    end

    always_comb begin
        o_eoc_out     = '0;
        o_busy        = '0;
        o_timeout_err = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            o_eoc_out[i]     = (r_state[i] == ST_DONE);
            o_busy[i]        = (r_state[i] == ST_BUSY);
            o_timeout_err[i] = (r_state[i] == ST_ERR);
        end
    end

    assign o_all_done       = &o_eoc_out;
    assign o_irq            = r_irq;
    assign io_req.req_valid = r_req_valid;
    assign io_req.req_ch    = r_req_ch;
    assign io_req.req_err   = r_req_err;

endmodule

// File: doc/eoc_status_bank.md
# eoc_status_bank

Parametrised multi-channel successor to the single-bit end-of-conversion flag. It tracks NUM_CH independent sort/conversion engines. Each channel has a start/done/error state machine, a per-run watchdog and a lowest-index-first acknowledge handshake toward the controller. It sits between the sort datapaths (start/preset strobes) and the top-level control FSM or host, which reads status and acknowledges completions.

## Interface
Parameters:
- NUM_CH, 4, number of channels (≥1)
- CH_W, $clog2(NUM_CH) (min 1), width of channel index
- TO_W, 16, watchdog counter and limit width

Ports:
- clk  in  1  system clock, all flops rising-edge
- rst  in  1  asynchronous, active-high reset
- start  in  NUM_CH  per-channel run start strobe
- preset_eoc  in  NUM_CH  per-channel done strobe from datapath
- clear_eoc  in  NUM_CH  per-channel forced clear
- timeout_limit  in  TO_W  watchdog limit in cycles, latched per channel on start; 0 = watchdog disabled
- irq_en  in  NUM_CH  per-channel interrupt enable
- ack  in  1  acknowledge of the currently presented request
- eoc_out  out  NUM_CH  channel in DONE
- busy  out  NUM_CH  channel in BUSY
- timeout_err  out  NUM_CH  channel in ERR
- req_valid  out  1  a DONE/ERR channel is presented
- req_ch  out  CH_W  index of presented channel
- req_err  out  1  presented channel is in ERR (else DONE)
- irq  out  1  registered OR of enabled pending channels
- all_done  out  1  every channel in DONE

## Operation
- Each channel has a 2-bit state (IDLE, BUSY, DONE, ERR), a TO_W counter `cnt` and a latched limit `lim`.
- Per-channel priority, evaluated each edge: clear_eoc > start > preset_eoc > ack-of-this-channel > watchdog.
  - clear_eoc: any state → IDLE.
  - start: any state → BUSY, cnt←0, lim←timeout_limit.
  - preset_eoc: IDLE or BUSY → DONE. In DONE or ERR it has no effect.
  - ack while req_valid=1 and req_ch=this channel: DONE/ERR → IDLE.
  - watchdog: in BUSY with lim≠0, if cnt==lim−1 → ERR, else cnt←cnt+1. With lim=0, cnt holds and the channel never times out.
- eoc_out, busy and timeout_err are decoded directly from the state flops, with no combinational path from inputs.
- Arbiter:
  - When req_valid=0, it selects the lowest-index channel in DONE or ERR.
  - It registers req_valid=1, req_ch and req_err.
  - While req_valid=1, req_ch is held stable.
  - req_valid drops after an edge with ack=1, or when the presented channel leaves DONE/ERR by clear_eoc or start.
  - After every drop, req_valid stays low for at least one cycle before re-arbitration.
- ack while req_valid=0 is ignored.
- irq ← |((eoc_out|timeout_err) & irq_en), registered.
- all_done = &eoc_out, combinational from state flops.

## Timing
- Reset: all states IDLE; cnt=0, lim=0, eoc_out=0, busy=0, timeout_err=0, req_valid=0, req_ch=0, req_err=0, irq=0. all_done=0 unless NUM_CH channels are in DONE, so it is 0 after reset.
- Reset mid-run aborts immediately and asynchronously; no pending request survives.
- Latencies:
  - start at edge t → busy=1 after t.
  - preset_eoc at edge t → eoc_out=1 after t, req_valid=1 after t+1 (if no request is held), irq=1 after t+1.
- Watchdog: start at edge t with timeout_limit=L → timeout_err=1 after edge t+L, unless preset_eoc arrives at or before edge t+L. Simultaneous preset and timeout resolves to DONE.
- ack at edge t → channel IDLE and req_valid=0 after t. The next request can appear after t+1 at the earliest.
- Simultaneous clear_eoc and preset_eoc on one channel: clear wins (IDLE), matching legacy flag behaviour.
- Simultaneous start and ack on the presented channel: start wins (BUSY); req_valid drops.
- timeout_limit changes during BUSY have no effect until the next start.

## Test plan
- Reset, NUM_CH=4: assert rst mid-BUSY on ch1 → all outputs 0 asynchronously; after release, ch1 stays IDLE without a new start.
- Single run: start[2] at edge 0, timeout_limit=10, preset_eoc[2] at edge 5 → eoc_out=4'b0100 after edge 5; req_valid=1, req_ch=2, req_err=0 after edge 6; ack at edge 8 → eoc_out=0 and req_valid=0 after edge 8.
- Watchdog: start[0] with timeout_limit=3 at edge 0, no preset → timeout_err[0]=1 after edge 3, req_err=1. Repeat with preset at edge 3 → DONE, not ERR. With timeout_limit=0 and no preset for 1000 cycles → busy stays 1.
- Arbitration: preset_eoc on ch3, ch1, ch0 in the same edge → requests presented in order 0, 1, 3. req_ch is stable while valid; req_valid is low for ≥1 cycle between grants.
- Conflicts:
  - clear_eoc[1] and preset_eoc[1] together → ch1 IDLE.
  - clear_eoc on the presented channel → req_valid drops, then the next channel is presented.
  - start and ack together on the presented channel → ch BUSY.
- irq/all_done: irq_en=4'b0010, ch0 DONE → irq=0; ch1 DONE → irq=1 one cycle later; all four DONE → all_done=1 in the same cycle as the last eoc_out.
